// File: rtl/bus_pkg.sv
// Shared bus definitions: address/data widths and the master-port
// command constants and command record.
package bus_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 8;

  // Master-port front end defaults
  localparam int MP_FIFO_DEPTH     = 4;
  localparam int MP_TIMEOUT_CYCLES = 1023;

  // One queued host command (FIFO entry)
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
  } mp_cmd_t;

  // Master-port transaction FSM
  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_REQ  = 2'd1,
    MP_RESP = 2'd2
  } mp_state_e;

endpackage

// File: rtl/mp_cmd_fifo.sv
// Synchronous command FIFO for the master-port front end.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i / wdata_i    write an entry (ignored while full)
//   pop_i               drop the head entry (ignored while empty)
//   rdata_o             current head entry (valid while !empty_o)
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module mp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // The head is read combinationally so the consumer can register it
  // on the same edge that pops it.
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only read while occupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_master_port.sv
// Host-side request front end for one bus master port.
// Queues host commands, presents one at a time on m_req/m_addr/m_wdata/m_we
// until the bus signals completion (or the watchdog expires), and returns
// read data / error status through a response register.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_*                         host command channel (valid/ready)
//   resp_*                        host response channel (valid/ready)
//   m_req/m_addr/m_wdata/m_we     request to the bus master interface
//   m_gnt/m_ready/m_rdata/m_err   status/completion from the bus
//   pending_o                     queued commands, excluding the one in flight
module bus_master_port
  import bus_pkg::*;
#(
  parameter int DEPTH          = MP_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = MP_TIMEOUT_CYCLES
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata_i,
  input  logic                       cmd_we_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [DATA_WIDTH-1:0]      resp_rdata_o,
  output logic                       resp_err_o,
  output logic                       resp_timeout_o,
  output logic                       m_req_o,
  output logic [ADDR_WIDTH-1:0]      m_addr_o,
  output logic [DATA_WIDTH-1:0]      m_wdata_o,
  output logic                       m_we_o,
  input  logic                       m_gnt_i,
  input  logic                       m_ready_i,
  input  logic [DATA_WIDTH-1:0]      m_rdata_i,
  input  logic                       m_err_i,
  output logic [$clog2(DEPTH+1)-1:0] pending_o
);

  localparam int PEND_W = $clog2(DEPTH+1);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES-1);
  localparam logic [TCNT_W-1:0] TMO_SAT  = TCNT_W'(TIMEOUT_CYCLES);

  // Grant is informational only; the request is never gated by it.
  logic unused_gnt;
  assign unused_gnt = m_gnt_i;

  // ---------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------
  mp_cmd_t           fifo_wdata;
  mp_cmd_t           fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PEND_W-1:0] fifo_count;
  logic [PEND_W-1:0] fifo_count_nx;

  assign fifo_wdata = '{addr: cmd_addr_i, wdata: cmd_wdata_i, we: cmd_we_i};

  mp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(mp_cmd_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------
  // Transaction FSM and watchdog
  // ---------------------------------------------------------------
  mp_state_e             state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  m_req_q, m_req_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  m_we_q, m_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic [TCNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                  start;

  // cmd_ready is registered, so a push is always legal when it is high.
  assign fifo_push = cmd_valid_i && cmd_ready_q;
  assign start     = (state_q == MP_IDLE) && !fifo_empty && !resp_valid_q;
  assign fifo_pop  = start;

  always_comb begin
    state_d        = state_q;
    m_req_d        = m_req_q;
    m_addr_d       = m_addr_q;
    m_wdata_d      = m_wdata_q;
    m_we_d         = m_we_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;
    tmo_cnt_d      = tmo_cnt_q;

    // Ready tracks the occupancy the FIFO will have after this edge.
    fifo_count_nx = fifo_count + PEND_W'(fifo_push && !fifo_full)
                               - PEND_W'(fifo_pop);
    cmd_ready_d   = (fifo_count_nx != PEND_W'(DEPTH));

    case (state_q)
      MP_IDLE: begin
        if (start) begin
          state_d   = MP_REQ;
          m_req_d   = 1'b1;
          m_addr_d  = fifo_head.addr;
          m_wdata_d = fifo_head.wdata;
          m_we_d    = fifo_head.we;
          tmo_cnt_d = '0;
        end
      end
      MP_REQ: begin
        if (tmo_cnt_q != TMO_SAT) tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (m_ready_i) begin
          state_d        = MP_RESP;
          m_req_d        = 1'b0;
          resp_valid_d   = 1'b1;
          resp_rdata_d   = m_we_q ? '0 : m_rdata_i;
          resp_err_d     = m_err_i;
          resp_timeout_d = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d        = MP_RESP;
          m_req_d        = 1'b0;
          resp_valid_d   = 1'b1;
          resp_rdata_d   = '0;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
        end
      end
      MP_RESP: begin
        // Leaving through IDLE guarantees a low cycle on m_req between
        // transactions.
        if (resp_ready_i) begin
          state_d      = MP_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = MP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= MP_IDLE;
      cmd_ready_q    <= 1'b0;
      m_req_q        <= 1'b0;
      m_addr_q       <= '0;
      m_wdata_q      <= '0;
      m_we_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      m_req_q        <= m_req_d;
      m_addr_q       <= m_addr_d;
      m_wdata_q      <= m_wdata_d;
      m_we_q         <= m_we_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign m_req_o        = m_req_q;
  assign m_addr_o       = m_addr_q;
  assign m_wdata_o      = m_wdata_q;
  assign m_we_o         = m_we_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_err_o     = resp_err_q;
  assign resp_timeout_o = resp_timeout_q;
  assign pending_o      = fifo_count;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_bus_master_port;
  import bus_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [DATA_WIDTH-1:0] cmd_wdata = '0;
  logic                  cmd_we = 1'b0;
  logic                  resp_valid_o;
  logic                  resp_ready = 1'b0;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_err_o;
  logic                  resp_timeout_o;
  logic                  m_req_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic                  m_we_o;
  logic                  m_gnt = 1'b0;
  logic                  m_ready = 1'b0;
  logic [DATA_WIDTH-1:0] m_rdata = '0;
  logic                  m_err = 1'b0;
  logic [2:0]            pending_o;

  int total = 0;
  int bad   = 0;

  bus_master_port #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_we_i(cmd_we),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .resp_timeout_o(resp_timeout_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_we_o(m_we_o), .m_gnt_i(m_gnt), .m_ready_i(m_ready),
    .m_rdata_i(m_rdata), .m_err_i(m_err), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and hold it until the registered ready lets it in.
  task automatic push(input logic [13:0] a, input logic [7:0] d, input logic w);
    int n = 0;
    cmd_addr = a; cmd_wdata = d; cmd_we = w; cmd_valid = 1'b1;
    while (cmd_ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    check("push_ready", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (m_req_o !== 1'b1 && n < 40) begin tick(); n++; end
    check("req_rise", 32'(m_req_o), 32'd1);
  endtask

  // Serve one transaction, check the request fields and the response.
  task automatic complete(input logic [13:0] a, input logic [7:0] d, input logic w,
                          input logic [7:0] bus_rd, input logic bus_err,
                          input logic [7:0] exp_rd);
    wait_req();
    check("req_addr", 32'(m_addr_o), 32'(a));
    check("req_wdata", 32'(m_wdata_o), 32'(d));
    check("req_we", 32'(m_we_o), 32'(w));
    m_ready = 1'b1; m_rdata = bus_rd; m_err = bus_err;
    tick();
    m_ready = 1'b0; m_rdata = 8'h00; m_err = 1'b0;
    check("resp_valid", 32'(resp_valid_o), 32'd1);
    check("resp_rdata", 32'(resp_rdata_o), 32'(exp_rd));
    check("resp_err", 32'(resp_err_o), 32'(bus_err));
    check("resp_tmo", 32'(resp_timeout_o), 32'd0);
    check("req_drop", 32'(m_req_o), 32'd0);
    $display("txn addr=%h we=%0d rdata=%h err=%0d tmo=%0d",
             a, w, resp_rdata_o, resp_err_o, resp_timeout_o);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_clear", 32'(resp_valid_o), 32'd0);
    check("req_gap", 32'(m_req_o), 32'd0);
  endtask

  logic [13:0] f_addr [10];
  logic [7:0]  f_wdata [10];
  logic        f_we [10];
  int          push_idx;

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    check("rst_req", 32'(m_req_o), 32'd0);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    check("rst_addr", 32'(m_addr_o), 32'd0);
    rst_n = 1'b1;
    check("rel_ready0", 32'(cmd_ready_o), 32'd0);
    tick();
    check("rel_ready1", 32'(cmd_ready_o), 32'd1);

    // ---------------- 1: single write, 6-cycle bus latency ----------------
    cmd_addr = 14'h0010; cmd_wdata = 8'hA5; cmd_we = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("w_pend1", 32'(pending_o), 32'd1);
    check("w_req_e", 32'(m_req_o), 32'd0);
    tick();
    check("w_req_e1", 32'(m_req_o), 32'd1);
    check("w_addr", 32'(m_addr_o), 32'h0010);
    check("w_wdata", 32'(m_wdata_o), 32'hA5);
    check("w_pend0", 32'(pending_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      m_gnt = ~m_gnt;
      tick();
      check("w_hold", 32'(m_req_o), 32'd1);
      check("w_hold_addr", 32'(m_addr_o), 32'h0010);
    end
    m_gnt = 1'b0;
    complete(14'h0010, 8'hA5, 1'b1, 8'h77, 1'b0, 8'h00);

    // ---------------- 2: read with response backpressure ----------------
    push(14'h1004, 8'h00, 1'b0);
    wait_req();
    check("r_addr", 32'(m_addr_o), 32'h1004);
    check("r_we", 32'(m_we_o), 32'd0);
    m_ready = 1'b1; m_rdata = 8'h3C;
    tick();
    m_ready = 1'b0; m_rdata = 8'hFF;
    check("r_valid", 32'(resp_valid_o), 32'd1);
    check("r_rdata", 32'(resp_rdata_o), 32'h3C);
    push(14'h0123, 8'h5A, 1'b1);
    for (int k = 0; k < 5; k++) begin
      m_ready = (k == 2);  // stray completion while in RESP
      tick();
      m_ready = 1'b0;
      check("bp_valid", 32'(resp_valid_o), 32'd1);
      check("bp_rdata", 32'(resp_rdata_o), 32'h3C);
      check("bp_req", 32'(m_req_o), 32'd0);
      check("bp_pend", 32'(pending_o), 32'd1);
    end
    $display("txn addr=1004 we=0 rdata=%h err=%0d tmo=%0d",
             resp_rdata_o, resp_err_o, resp_timeout_o);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_release", 32'(resp_valid_o), 32'd0);
    check("bp_gap", 32'(m_req_o), 32'd0);
    complete(14'h0123, 8'h5A, 1'b1, 8'h11, 1'b0, 8'h00);

    // Stray completion in IDLE must not produce a response.
    m_ready = 1'b1; m_rdata = 8'hAA;
    tick();
    m_ready = 1'b0;
    tick();
    check("stray_valid", 32'(resp_valid_o), 32'd0);
    check("stray_req", 32'(m_req_o), 32'd0);

    // ---------------- 3: fill, overflow attempt, drain with wrap ----------------
    for (int i = 0; i < 10; i++) begin
      f_addr[i]  = 14'h0300 + 14'(i);
      f_wdata[i] = 8'h20 + 8'(i);
      f_we[i]    = (i % 2 == 0);
    end
    for (int i = 0; i < 5; i++) push(f_addr[i], f_wdata[i], f_we[i]);
    check("full_ready", 32'(cmd_ready_o), 32'd0);
    check("full_pend", 32'(pending_o), 32'd4);
    cmd_addr = 14'h3FFF; cmd_wdata = 8'hEE; cmd_we = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("ovf_pend", 32'(pending_o), 32'd4);
    check("ovf_ready", 32'(cmd_ready_o), 32'd0);
    push_idx = 5;
    for (int i = 0; i < 10; i++) begin
      complete(f_addr[i], f_wdata[i], f_we[i], 8'hC0 + 8'(i), 1'b0,
               f_we[i] ? 8'h00 : 8'hC0 + 8'(i));
      if (push_idx < 10) begin
        push(f_addr[push_idx], f_wdata[push_idx], f_we[push_idx]);
        push_idx++;
      end
    end
    check("drain_pend", 32'(pending_o), 32'd0);

    // ---------------- 4: watchdog at 16 cycles ----------------
    push(14'h0200, 8'h44, 1'b1);
    wait_req();
    m_rdata = 8'h77;
    for (int k = 1; k < 16; k++) begin
      tick();
      check("tmo_hold", 32'(m_req_o), 32'd1);
    end
    tick();
    check("tmo_req", 32'(m_req_o), 32'd0);
    check("tmo_valid", 32'(resp_valid_o), 32'd1);
    check("tmo_err", 32'(resp_err_o), 32'd1);
    check("tmo_flag", 32'(resp_timeout_o), 32'd1);
    check("tmo_rdata", 32'(resp_rdata_o), 32'd0);
    $display("txn addr=0200 we=1 rdata=%h err=%0d tmo=%0d",
             resp_rdata_o, resp_err_o, resp_timeout_o);
    m_rdata = 8'h00;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("tmo_clear", 32'(resp_valid_o), 32'd0);

    // Completion on the last allowed cycle beats the watchdog.
    push(14'h0201, 8'h00, 1'b0);
    wait_req();
    repeat (15) tick();
    check("late_hold", 32'(m_req_o), 32'd1);
    m_ready = 1'b1; m_rdata = 8'h5E;
    tick();
    m_ready = 1'b0; m_rdata = 8'h00;
    check("late_valid", 32'(resp_valid_o), 32'd1);
    check("late_rdata", 32'(resp_rdata_o), 32'h5E);
    check("late_err", 32'(resp_err_o), 32'd0);
    check("late_tmo", 32'(resp_timeout_o), 32'd0);
    $display("txn addr=0201 we=0 rdata=%h err=%0d tmo=%0d",
             resp_rdata_o, resp_err_o, resp_timeout_o);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // ---------------- 5: bus error on read ----------------
    push(14'h3800, 8'h00, 1'b0);
    complete(14'h3800, 8'h00, 1'b0, 8'h99, 1'b1, 8'h99);

    // ---------------- 6: reset while a request is outstanding ----------------
    push(14'h0400, 8'h01, 1'b1);
    push(14'h0401, 8'h02, 1'b1);
    push(14'h0402, 8'h03, 1'b0);
    tick();
    check("mr_req", 32'(m_req_o), 32'd1);
    check("mr_pend", 32'(pending_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_async", 32'(m_req_o), 32'd0);
    check("mr_pend_async", 32'(pending_o), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("mr_ready", 32'(cmd_ready_o), 32'd1);
    check("mr_pend0", 32'(pending_o), 32'd0);
    check("mr_valid", 32'(resp_valid_o), 32'd0);
    repeat (3) tick();
    check("mr_idle_req", 32'(m_req_o), 32'd0);
    check("mr_idle_valid", 32'(resp_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
